// File: rtl/wb_trace_fifo.sv
// ----------------------------------------------------------------------------
// wb_trace_fifo
//
// Records every architectural register write-back retired by the WB stage as
// an ordered trace. Each qualifying write (wb_en=1, destination not XZR) gets a
// sequence number and is buffered in a first-word-fall-through FIFO that
// drains over a valid/ready port. When the FIFO is full and nothing drains,
// the event is dropped. A drop sets the sticky overflow flag and bumps a
// saturating drop counter. The sequence number still advances on a drop, so
// gaps in out_seq show where events were lost.
//
// Optional feature, selected by the macro WB_TRACE_MATCH_EN:
//   adds match_data (in) and match_hit (out). match_hit latches when a
//   qualifying event carries wb_data == match_data. Dropped events count too.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears seq as well)
//   flush        synchronous clear of FIFO contents and error state
//   wb_en        register-file write enable from WB
//   wb_reg       destination register index
//   wb_data      write-back data
//   match_data   value to watch for (WB_TRACE_MATCH_EN only)
//   match_hit    sticky match indicator (WB_TRACE_MATCH_EN only)
//   out_valid    head entry available
//   out_ready    consumer accepts the head entry
//   out_reg      head register index (0 when empty)
//   out_data     head data (0 when empty)
//   out_seq      head sequence number (0 when empty)
//   count        current occupancy
//   overflow     sticky, at least one event was dropped
//   drop_cnt     number of dropped events, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module wb_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WORD  = 64,
    parameter int SEQ_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wb_en,
    input  logic [4:0]               wb_reg,
    input  logic [WORD-1:0]          wb_data,
`ifdef WB_TRACE_MATCH_EN
    input  logic [WORD-1:0]          match_data,
    output logic                     match_hit,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_reg,
    output logic [WORD-1:0]          out_data,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [4:0]       r_memReg  [DEPTH];
    logic [WORD-1:0]  r_memData [DEPTH];
    logic [SEQ_W-1:0] r_memSeq  [DEPTH];

    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic [SEQ_W-1:0] r_seq;
    logic             r_overflow;
    logic [15:0]      r_dropCnt;

    logic w_live;
    logic w_event;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Flush and reset both swallow the same-cycle event, so nothing is
    // counted as an event, push or pop while either is high.
    assign w_live  = !rst && !flush;
    assign w_event = w_live && wb_en && (wb_reg != 5'd31);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_pop   = w_live && (r_count != '0) && out_ready;
    // A full FIFO still accepts an event when the head leaves at the same edge.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    // Entry storage carries no reset: contents are only visible through the
    // out_* ports, and those are forced to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memReg[r_wrPtr]  <= wb_reg;
            r_memData[r_wrPtr] <= wb_data;
            r_memSeq[r_wrPtr]  <= r_seq;
        end
    end

    // Pointer, occupancy, sequence and drop bookkeeping. Flush clears the
    // buffer and the error state but keeps seq running, so a consumer can
    // still tell which events were lost across the flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else if (flush) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_event) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropCnt != 16'hFFFF) begin
                    r_dropCnt <= r_dropCnt + 1'b1;
                end
            end
        end
    end

`ifdef WB_TRACE_MATCH_EN
    logic r_matchHit;

    // Match is judged on every qualifying event, including ones that are
    // dropped, because the watcher cares that the value was produced.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_matchHit <= 1'b0;
        end else if (w_event && (wb_data == match_data)) begin
            r_matchHit <= 1'b1;
        end
    end

    assign match_hit = r_matchHit;
`endif

    assign out_valid = (r_count != '0);
    assign out_reg   = out_valid ? r_memReg[r_rdPtr]  : '0;
    assign out_data  = out_valid ? r_memData[r_rdPtr] : '0;
    assign out_seq   = out_valid ? r_memSeq[r_rdPtr]  : '0;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// ----------------------------------------------------------------------------
// tb_wb_trace_fifo
//
// Self-checking bench for wb_trace_fifo. The reference model holds the trace
// as a queue of entries plus scalar counters, and is advanced once per clock
// from the inputs applied for that edge. After each edge every DUT output is
// compared against the model. Directed scenarios pin specific literal values,
// and then a long randomized run varies drain pressure, flushes and resets.
// The match feature is exercised when WB_TRACE_MATCH_EN is defined.
// ----------------------------------------------------------------------------
module tb_wb_trace_fifo;

    localparam int DEPTH = 8;
    localparam int WORD  = 64;
    localparam int SEQ_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [63:0] FACT20 = 64'h21C3_677C_82B4_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              wbEn;
    logic [4:0]        wbReg;
    logic [WORD-1:0]   wbData;
    logic              outValid;
    logic              outReady;
    logic [4:0]        outReg;
    logic [WORD-1:0]   outData;
    logic [SEQ_W-1:0]  outSeq;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [15:0]       dropCnt;
    logic [WORD-1:0]   matchData;
`ifdef WB_TRACE_MATCH_EN
    logic              matchHit;
`endif

    typedef struct {
        logic [4:0]  r;
        logic [63:0] d;
        logic [15:0] s;
    } entry_t;

    entry_t mq[$];
    int     mSeq;
    bit     mOverflow;
    int     mDrop;
    bit     mMatch;

    int total = 0;
    int bad   = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    wb_trace_fifo #(.DEPTH(DEPTH), .WORD(WORD), .SEQ_W(SEQ_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wb_en      (wbEn),
        .wb_reg     (wbReg),
        .wb_data    (wbData),
`ifdef WB_TRACE_MATCH_EN
        .match_data (matchData),
        .match_hit  (matchHit),
`endif
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_reg    (outReg),
        .out_data   (outData),
        .out_seq    (outSeq),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (dropCnt)
    );

    // One comparison: counts it, reports a mismatch with actual and expected.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelStep();
        bit     ev;
        bit     pop;
        bit     full;
        entry_t e;
        if (rst) begin
            mq.delete();
            mSeq      = 0;
            mOverflow = 0;
            mDrop     = 0;
            mMatch    = 0;
        end else if (flush) begin
            mq.delete();
            mOverflow = 0;
            mDrop     = 0;
            mMatch    = 0;
        end else begin
            ev   = wbEn && (wbReg != 5'd31);
            full = (mq.size() == DEPTH);
            pop  = (mq.size() != 0) && outReady;
            if (pop) begin
                e = mq.pop_front();
            end
            if (ev) begin
                if (!full || pop) begin
                    e.r = wbReg;
                    e.d = wbData;
                    e.s = 16'(mSeq);
                    mq.push_back(e);
                end else begin
                    mOverflow = 1;
                    if (mDrop < 65535) mDrop++;
                end
`ifdef WB_TRACE_MATCH_EN
                if (wbData == matchData) mMatch = 1;
`endif
                mSeq = (mSeq + 1) % 65536;
            end
        end
    endtask

    // Compare all outputs against the model state after the latest edge.
    task automatic compareModel();
        bit has;
        has = (mq.size() != 0);
        checkOutput("out_valid", 64'(outValid), 64'(has));
        checkOutput("out_reg",   64'(outReg),   has ? 64'(mq[0].r) : 64'd0);
        checkOutput("out_data",  outData,       has ? mq[0].d : 64'd0);
        checkOutput("out_seq",   64'(outSeq),   has ? 64'(mq[0].s) : 64'd0);
        checkOutput("count",     64'(count),    64'(mq.size()));
        checkOutput("overflow",  64'(overflow), 64'(mOverflow));
        checkOutput("drop_cnt",  64'(dropCnt),  64'(mDrop));
`ifdef WB_TRACE_MATCH_EN
        checkOutput("match_hit", 64'(matchHit), 64'(mMatch));
`endif
    endtask

    // Apply one cycle of inputs, step the model, then check after the edge.
    task automatic applyStimulus(input bit rs, input bit fl, input bit en,
                                 input logic [4:0] r, input logic [63:0] d,
                                 input bit rdy);
        rst      = rs;
        flush    = fl;
        wbEn     = en;
        wbReg    = r;
        wbData   = d;
        outReady = rdy;
        modelStep();
        @(negedge clk);
        compareModel();
    endtask

    initial begin
        int pct;
        matchData = FACT20;

        // Reset and check the reset values directly.
        applyStimulus(1, 0, 0, 5'd0, 64'd0, 0);
        applyStimulus(1, 0, 0, 5'd0, 64'd0, 0);
        checkOutput("reset out_valid", 64'(outValid), 64'd0);
        checkOutput("reset count",     64'(count),    64'd0);
        checkOutput("reset overflow",  64'(overflow), 64'd0);
        checkOutput("reset drop_cnt",  64'(dropCnt),  64'd0);
        checkOutput("reset out_data",  outData,       64'd0);

        // x9 = 6 appears one edge later, then drains on a ready pulse.
        applyStimulus(0, 0, 1, 5'd9, 64'h6, 0);
        checkOutput("x9 out_valid", 64'(outValid), 64'd1);
        checkOutput("x9 out_reg",   64'(outReg),   64'd9);
        checkOutput("x9 out_data",  outData,       64'd6);
        checkOutput("x9 out_seq",   64'(outSeq),   64'd0);
        checkOutput("x9 count",     64'(count),    64'd1);
        applyStimulus(0, 0, 0, 5'd0, 64'd0, 1);
        checkOutput("x9 drained valid", 64'(outValid), 64'd0);
        checkOutput("x9 drained data",  outData,       64'd0);

        // XZR write is ignored and does not consume a sequence number.
        applyStimulus(1, 0, 0, 5'd0, 64'd0, 0);
        applyStimulus(0, 0, 1, 5'd31, 64'hFF, 0);
        checkOutput("xzr count", 64'(count), 64'd0);
        applyStimulus(0, 0, 1, 5'd2, 64'h22, 0);
        checkOutput("after xzr out_seq", 64'(outSeq), 64'd0);
        checkOutput("after xzr out_reg", 64'(outReg), 64'd2);
        applyStimulus(0, 0, 0, 5'd0, 64'd0, 1);
        applyStimulus(0, 0, 0, 5'd0, 64'd0, 1);
        checkOutput("empty pop count", 64'(count), 64'd0);

        // Ten writes into an eight-deep FIFO with no drain: two drops.
        applyStimulus(1, 0, 0, 5'd0, 64'd0, 0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(0, 0, 1, 5'(i), 64'(i * 100), 0);
        end
        checkOutput("full count",    64'(count),    64'd8);
        checkOutput("full overflow", 64'(overflow), 64'd1);
        checkOutput("full drop_cnt", 64'(dropCnt),  64'd2);
        checkOutput("full head seq", 64'(outSeq),   64'd0);
        checkOutput("full head reg", 64'(outReg),   64'd1);

        // Full with a simultaneous pop: the write is kept as the new tail.
        applyStimulus(0, 0, 1, 5'd11, 64'hB0B, 1);
        checkOutput("full+pop count",    64'(count),   64'd8);
        checkOutput("full+pop drop_cnt", 64'(dropCnt), 64'd2);
        for (int k = 0; k < 8; k++) begin
            checkOutput("drain seq", 64'(outSeq), (k < 7) ? 64'(k + 1) : 64'd10);
            checkOutput("drain reg", 64'(outReg), (k < 7) ? 64'(k + 2) : 64'd11);
            applyStimulus(0, 0, 0, 5'd0, 64'd0, 1);
        end
        checkOutput("drained count", 64'(count), 64'd0);

        // Flush with a same-cycle write: buffer and errors clear, seq holds.
        for (int i = 3; i <= 5; i++) begin
            applyStimulus(0, 0, 1, 5'(i), 64'(i), 0);
        end
        checkOutput("pre-flush count", 64'(count), 64'd3);
        applyStimulus(0, 1, 1, 5'd6, 64'h66, 0);
        checkOutput("flush count",     64'(count),    64'd0);
        checkOutput("flush overflow",  64'(overflow), 64'd0);
        checkOutput("flush drop_cnt",  64'(dropCnt),  64'd0);
        checkOutput("flush out_valid", 64'(outValid), 64'd0);
        applyStimulus(0, 0, 1, 5'd7, 64'h77, 0);
        checkOutput("post-flush seq", 64'(outSeq), 64'd14);

`ifdef WB_TRACE_MATCH_EN
        // Sticky match on fact(20) written to x0, cleared by flush.
        applyStimulus(1, 0, 0, 5'd0, 64'd0, 0);
        applyStimulus(0, 0, 1, 5'd0, 64'h1234, 0);
        checkOutput("no match", 64'(matchHit), 64'd0);
        applyStimulus(0, 0, 1, 5'd0, FACT20, 0);
        checkOutput("match set", 64'(matchHit), 64'd1);
        applyStimulus(0, 0, 0, 5'd0, 64'd0, 1);
        checkOutput("match held", 64'(matchHit), 64'd1);
        applyStimulus(0, 1, 0, 5'd0, 64'd0, 0);
        checkOutput("match flushed", 64'(matchHit), 64'd0);
`endif

        // Randomized run; drain probability changes per block to reach both
        // the empty and the full/overflowing regimes.
        for (int blk = 0; blk < 15; blk++) begin
            case (blk % 3)
                0:       pct = 10;
                1:       pct = 50;
                default: pct = 95;
            endcase
            for (int c = 0; c < 200; c++) begin
                logic [4:0]  r;
                logic [63:0] d;
                r = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                d = {$urandom, $urandom};
                if ($urandom_range(0, 49) == 0) d = FACT20;
                applyStimulus($urandom_range(0, 299) == 0,
                              $urandom_range(0, 59) == 0,
                              $urandom_range(0, 99) < 75,
                              r, d,
                              $urandom_range(0, 99) < pct);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Captures every architectural register write-back retired by the LEGv8 CPU's WB stage and buffers it as an ordered trace for the self-checking bench or a debug port. It sits directly downstream of the data path's write-back mux, taps the register-file write strobe, index and data, and presents entries on a valid/ready drain port. Overflow is flagged and counted, never silently hidden.

## Interface

- DEPTH, 8: FIFO entries; power of two, ≥ 2.
- WORD, 64: data width, matches the data-path word.
- SEQ_W, 16: width of the per-event sequence number.

Ports:

- clk  in  1  : the block's only clock; all state updates on its rising edge.
- rst  in  1  : one clock; reset is synchronous and active-high.
- flush  in  1  : synchronous clear of FIFO and error state.
- wb_en  in  1  : register-file write enable from WB.
- wb_reg  in  5  : destination register index.
- wb_data  in  WORD  : write-back data.
- out_valid  out  1  : head entry available.
- out_ready  in  1  : consumer accepts head.
- out_reg  out  5  : head register index.
- out_data  out  WORD  : head data.
- out_seq  out  SEQ_W  : head sequence number.
- count  out  $clog2(DEPTH)+1  : occupancy.
- overflow  out  1  : sticky, an event was dropped.
- drop_cnt  out  16  : dropped events, saturating at 16'hFFFF.

## Operation

- Qualifying event: wb_en=1 and wb_reg≠31. Writes to XZR are ignored and do not advance the sequence counter.
- Each qualifying event is tagged with the current seq value. seq then increments, wrapping at 2^SEQ_W. It increments whether the event is stored or dropped, so gaps in out_seq expose drops.
- Push: a qualifying event when count<DEPTH, or when count==DEPTH with a pop in the same cycle.
- Drop: a qualifying event with count==DEPTH and no pop. On a drop, overflow←1 and drop_cnt increments, saturating.
- Pop: out_valid && out_ready. out_ready while empty has no effect.
- The drain is first-word-fall-through. out_valid = (count≠0). out_reg, out_data and out_seq show the head entry and are driven 0 when out_valid=0.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately.
- flush has priority over push and pop in the same cycle. The same-cycle event is discarded and seq does not advance. flush clears count, pointers, overflow and drop_cnt; seq is preserved.
- rst clears everything, including seq=0. Reset asserted mid-stream discards all buffered entries.
- Reset values: out_valid=0, out_reg=0, out_data=0, out_seq=0, count=0, overflow=0, drop_cnt=0.

## Timing

- Capture latency is 1 cycle. An event sampled at edge N is visible on out_* after edge N.
- There is no bypass. A push into an empty FIFO with out_ready=1 is not popped in the same cycle.
- When a pop occurs at edge N, the next head is presented after edge N.
- count, overflow and drop_cnt update at the same edge as the push, pop or drop that changes them.
- Sustained throughput is one event per cycle in and one per cycle out.

## Configuration

- WB_TRACE_MATCH_EN defined:
  - Adds port match_data  in  WORD and port match_hit  out  1.
  - match_hit is set at the edge capturing a qualifying event whose wb_data==match_data. It stays set until rst or flush; reset value is 0.
  - Dropped events still evaluate the match.
- WB_TRACE_MATCH_EN undefined: neither port exists and there is no comparator logic.

## Test plan

- Write-back of x9=0x6 after rst → next cycle out_valid=1, out_reg=9, out_data=6, out_seq=0, count=1. Pulse out_ready → out_valid=0, out_data=0.
- wb_en=1, wb_reg=31, data 0xFF → count stays 0; seq unchanged, so the next valid write carries out_seq=0.
- DEPTH=8, out_ready=0, 10 consecutive writes to x1..x10 → count=8, overflow=1, drop_cnt=2. Draining yields out_seq 0..7 and out_reg 1..8.
- FIFO full, one qualifying write with out_ready=1 → count stays 8, no drop, new entry becomes the tail.
- 3 entries buffered, flush together with a qualifying write → count=0, overflow=0, out_valid=0. The next write carries out_seq=3.
- With WB_TRACE_MATCH_EN, match_data=64'h21C3_677C_82B4_0000 (fact(20)): a write of that value to x0 → match_hit=1 after the capturing edge; it stays high until flush.
